// File: rtl/alu_cond_pkg.sv
// Shared definitions for the ALU commit stage: condition codes, NZCV bit
// positions and the op-class helper used by the flag merge.
package alu_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // Logical/move ops leave C and V alone; everything else is arithmetic.
    function automatic logic is_logic_op(input logic [3:0] alu_op);
        case (alu_op)
            4'd0, 4'd1, 4'd8, 4'd9,
            4'd12, 4'd13, 4'd14, 4'd15: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_cond_commit_cond_eval.sv
// Combinational ARM-style condition evaluator: (cond, nzcv) -> pass.
module cond_eval
    import alu_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[NZCV_N];
    assign z = nzcv[NZCV_Z];
    assign c = nzcv[NZCV_C];
    assign v = nzcv[NZCV_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_cond_commit.sv
// Conditional commit stage: evaluates cond, merges NZCV, gates write-back.
// Define ALU_COND_FWD_EN to forward staged flags instead of interlocking.
module alu_cond_commit
    import alu_cond_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [3:0]        in_alu_op,
    input  logic              in_set_flags,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_nzcv,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wr_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_we,
    output logic              out_executed,
    output logic [3:0]        flags,
    output logic              c_flag
);

    logic              out_valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [RD_W-1:0]   rd_reg;
    logic              we_reg;
    logic              exec_reg;
    logic              fwe_reg;
    logic [3:0]        nzcv_reg;
    logic [3:0]        flags_reg;

    logic [3:0] eff;
    logic       interlock;
    logic       pass;
    logic       in_fire;
    logic       out_fire;
    logic [3:0] nzcv_next;

`ifdef ALU_COND_FWD_EN
    assign eff       = (out_valid_reg && fwe_reg) ? nzcv_reg : flags_reg;
    assign interlock = 1'b0;
`else
    // Without forwarding, hold off the next instruction until the flags land.
    assign eff       = flags_reg;
    assign interlock = out_valid_reg & fwe_reg;
`endif

    assign in_ready = (~out_valid_reg | out_ready) & ~interlock;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_reg & out_ready;

    cond_eval u_cond_eval (
        .cond (in_cond),
        .nzcv (eff),
        .pass (pass)
    );

    assign nzcv_next = is_logic_op(in_alu_op)
                     ? {in_nzcv[NZCV_N], in_nzcv[NZCV_Z], eff[NZCV_C], eff[NZCV_V]}
                     : in_nzcv;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            data_reg      <= '0;
            rd_reg        <= '0;
            we_reg        <= 1'b0;
            exec_reg      <= 1'b0;
            fwe_reg       <= 1'b0;
            nzcv_reg      <= 4'b0000;
            flags_reg     <= 4'b0000;
        end else begin
            // The outgoing entry commits its flags even when replaced this edge.
            if (out_fire && fwe_reg)
                flags_reg <= nzcv_reg;

            if (in_fire) begin
                out_valid_reg <= 1'b1;
                data_reg      <= in_result;
                rd_reg        <= in_rd;
                we_reg        <= in_wr_rd & pass;
                exec_reg      <= pass;
                fwe_reg       <= in_set_flags & pass;
                nzcv_reg      <= nzcv_next;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_data     = data_reg;
    assign out_rd       = rd_reg;
    assign out_we       = we_reg;
    assign out_executed = exec_reg;
    assign flags        = flags_reg;
    assign c_flag       = flags_reg[NZCV_C];

endmodule

// File: tb/tb_alu_cond_commit.sv
// Directed bench for alu_cond_commit: vector table plus hand-written sequences.
module tb_alu_cond_commit;

    localparam int DATA_W = 32;
    localparam int RD_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_cond;
    logic [3:0]        in_alu_op;
    logic              in_set_flags;
    logic [DATA_W-1:0] in_result;
    logic [3:0]        in_nzcv;
    logic [RD_W-1:0]   in_rd;
    logic              in_wr_rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_we;
    logic              out_executed;
    logic [3:0]        flags;
    logic              c_flag;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_cond_commit #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cond      (in_cond),
        .in_alu_op    (in_alu_op),
        .in_set_flags (in_set_flags),
        .in_result    (in_result),
        .in_nzcv      (in_nzcv),
        .in_rd        (in_rd),
        .in_wr_rd     (in_wr_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .out_executed (out_executed),
        .flags        (flags),
        .c_flag       (c_flag)
    );

    typedef struct {
        logic [3:0] init_flags;
        logic [3:0] cond;
        logic [3:0] op;
        logic       s;
        logic [3:0] nzcv;
        logic       wr;
        logic       exp_we;
        logic       exp_exec;
        logic [3:0] exp_flags;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic issue(input logic [3:0] cond, input logic [3:0] op, input logic s,
                         input logic [3:0] nzcv, input logic wr,
                         input logic [31:0] result, input logic [3:0] rd);
        int n;
        in_cond = cond; in_alu_op = op; in_set_flags = s; in_nzcv = nzcv;
        in_wr_rd = wr; in_result = result; in_rd = rd; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            errors++;
            checks++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1 within 20 cycles");
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int stalls;
        int n;
        logic fired;
        logic [31:0] held_data;

        vecs[0]  = '{4'b0000, 4'd14, 4'd2,  1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 4'b0110};
        vecs[1]  = '{4'b0010, 4'd14, 4'd0,  1'b1, 4'b1001, 1'b1, 1'b1, 1'b1, 4'b1010};
        vecs[2]  = '{4'b1001, 4'd10, 4'd13, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1001};
        vecs[3]  = '{4'b0100, 4'd12, 4'd2,  1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0100};
        vecs[4]  = '{4'b0100, 4'd0,  4'd13, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000};
        vecs[5]  = '{4'b0000, 4'd1,  4'd4,  1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 4'b0011};
        vecs[6]  = '{4'b0010, 4'd8,  4'd8,  1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0110};
        vecs[7]  = '{4'b0110, 4'd8,  4'd2,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0110};
        vecs[8]  = '{4'b0110, 4'd9,  4'd3,  1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0110};
        vecs[9]  = '{4'b1000, 4'd11, 4'd10, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001};
        vecs[10] = '{4'b0000, 4'd15, 4'd2,  1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[11] = '{4'b0001, 4'd6,  4'd15, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0101};
        vecs[12] = '{4'b0000, 4'd3,  4'd12, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000};
        vecs[13] = '{4'b1000, 4'd5,  4'd2,  1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1000};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_cond = 4'd14; in_alu_op = 4'd0; in_set_flags = 1'b0; in_result = '0;
        in_nzcv = 4'd0; in_rd = '0; in_wr_rd = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("reset_flags", 32'(flags), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_we", 32'(out_we), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_c_flag", 32'(c_flag), 32'h0);

        // Table: a setter op loads init_flags, then the vector under test.
        for (int i = 0; i < 14; i++) begin
            issue(4'd14, 4'd2, 1'b1, vecs[i].init_flags, 1'b0, 32'h0, 4'd0);
            issue(vecs[i].cond, vecs[i].op, vecs[i].s, vecs[i].nzcv, vecs[i].wr,
                  32'hA000_0000 + 32'(i), 4'(i));
            chk("vec_out_valid", 32'(out_valid), 32'h1);
            chk("vec_out_we", 32'(out_we), 32'(vecs[i].exp_we));
            chk("vec_out_executed", 32'(out_executed), 32'(vecs[i].exp_exec));
            chk("vec_out_data", out_data, 32'hA000_0000 + 32'(i));
            chk("vec_out_rd", 32'(out_rd), 32'(i));
            tick();
            chk("vec_flags", 32'(flags), 32'(vecs[i].exp_flags));
            chk("vec_c_flag", 32'(c_flag), 32'(vecs[i].exp_flags[1]));
            chk("vec_drained", 32'(out_valid), 32'h0);
            $display("vec %0d cond=%0d op=%0d we=%0b exec=%0b flags=%b", i,
                     vecs[i].cond, vecs[i].op, out_we, out_executed, flags);
        end

        // Back-to-back SUBS then MOVEQ: bubble count depends on forwarding.
        issue(4'd14, 4'd0, 1'b1, 4'b0000, 1'b0, 32'h0, 4'd0);
        tick();
        in_cond = 4'd14; in_alu_op = 4'd2; in_set_flags = 1'b1; in_nzcv = 4'b0110;
        in_wr_rd = 1'b1; in_result = 32'h0; in_rd = 4'd1; in_valid = 1'b1;
        chk("b2b_subs_ready", 32'(in_ready), 32'h1);
        tick();
        in_cond = 4'd0; in_alu_op = 4'd13; in_set_flags = 1'b0; in_nzcv = 4'b0000;
        in_wr_rd = 1'b1; in_result = 32'h0000_0077; in_rd = 4'd2;
        stalls = 0;
        while (!in_ready && stalls < 10) begin
            tick();
            stalls++;
        end
`ifdef ALU_COND_FWD_EN
        chk("b2b_stalls", 32'(stalls), 32'd0);
`else
        chk("b2b_stalls", 32'(stalls), 32'd1);
`endif
        tick();
        in_valid = 1'b0;
        chk("b2b_moveq_exec", 32'(out_executed), 32'h1);
        chk("b2b_moveq_we", 32'(out_we), 32'h1);
        chk("b2b_moveq_data", out_data, 32'h0000_0077);
        tick();
        chk("b2b_flags", 32'(flags), 32'b0110);
        $display("b2b stalls=%0d exec=%0b flags=%b", stalls, out_executed, flags);

        // Back-pressure: held entry is stable and its flags wait for release.
        out_ready = 1'b0;
        issue(4'd14, 4'd2, 1'b1, 4'b1100, 1'b1, 32'h1234_5678, 4'd5);
        held_data = 32'h1234_5678;
        in_cond = 4'd14; in_alu_op = 4'd0; in_set_flags = 1'b0; in_nzcv = 4'b0000;
        in_wr_rd = 1'b0; in_result = 32'hDEAD_BEEF; in_rd = 4'd6; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_data", out_data, held_data);
            chk("bp_flags", 32'(flags), 32'b0110);
            tick();
        end
        out_ready = 1'b1;
        #1;
        fired = in_ready;
        @(posedge clk);
        #1;
        chk("bp_release_flags", 32'(flags), 32'b1100);
        n = 0;
        while (!fired && n < 10) begin
            fired = in_ready;
            tick();
            n++;
        end
        chk("bp_second_accepted", 32'(fired), 32'h1);
        in_valid = 1'b0;
        chk("bp_second_data", out_data, 32'hDEAD_BEEF);
        tick();
        chk("bp_second_flags", 32'(flags), 32'b1100);
        $display("backpressure release flags=%b", flags);

        // Reset with a pending flag update discards it.
        out_ready = 1'b0;
        issue(4'd14, 4'd2, 1'b1, 4'b1111, 1'b1, 32'h5555_AAAA, 4'd7);
        chk("rst_pending_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_flags", 32'(flags), 32'h0);
        chk("rst_mid_out_data", out_data, 32'h0);
        chk("rst_mid_out_exec", 32'(out_executed), 32'h0);
        out_ready = 1'b1;
        tick();
        chk("rst_mid_flags_after", 32'(flags), 32'h0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'h1);
        $display("reset mid-op out_valid=%0b flags=%b", out_valid, flags);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
